// File: rtl/pipeline_spi_command_master.sv
// pipeline_spi_command_master: frames one command (opcode + 0/1/2 arg bytes) per mode-0 SPI slave-select window, capturing MISO bytes.
// Latency: SS falls the cycle after accept; SS low CLK_DIV*(1+16n) cycles, then GAP_CYCLES high, then one IDLE cycle.
// Backpressure: cmd_ready is high only in IDLE; a held cmd_valid waits until the next IDLE cycle.
//
// Ports:
//   clk, rst                     system clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake; cmd_opcode and cmd_arg are sampled only on it
//   busy                         high whenever not IDLE
//   rx_byte/rx_valid             last full MISO byte, with a one-cycle strobe when it updates
//   spi_sclk/spi_ss/spi_mosi     SPI master outputs (CPOL=0, CPHA=0, MSB first)
//   spi_miso                     SPI data in
module pipeline_spi_command_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_opcode,
    input  logic [15:0] cmd_arg,
    output logic        cmd_ready,
    output logic        busy,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        spi_sclk,
    output logic        spi_ss,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        GAP
    } state_t;

    state_t state, state_nxt;

    logic [DIV_W-1:0] div_cnt;   // cycles spent in the current half-period
    logic [4:0]       bit_cnt;   // index of the bit being shifted, 0-based
    logic [4:0]       bit_last;  // 8*n - 1 for the latched command
    logic [GAP_W-1:0] gap_cnt;
    logic             sclk_hi;   // current SHIFT half-period is the high one
    logic [23:0]      tx_sr;     // MSB is on the wire
    logic [6:0]       rx_sr;     // the 7 most recent MISO samples

    logic half_done, last_bit, gap_done;

    assign half_done = (div_cnt == DIV_LAST);
    assign last_bit  = (bit_cnt == bit_last);
    assign gap_done  = (gap_cnt == GAP_LAST);

    // Frame length matches the decoder's framing; unknown opcodes use the 3-byte default.
    function automatic logic [4:0] last_bit_for(input logic [7:0] op);
        case (op)
            8'h00, 8'hFF:                      return 5'd7;
            8'h01, 8'h02, 8'h03, 8'h06, 8'h0B: return 5'd15;
            default:                           return 5'd23;
        endcase
    endfunction

    // Left-aligned so the shifter can always drain from bit 23.
    function automatic logic [23:0] frame_for(input logic [7:0] op, input logic [15:0] arg);
        case (last_bit_for(op))
            5'd7:    return {op, 16'h0000};
            5'd15:   return {op, arg[7:0], 8'h00};
            default: return {op, arg};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        spi_ss    = 1'b1;
        spi_sclk  = 1'b0;
        spi_mosi  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = LEAD;
                end
            end
            LEAD: begin
                spi_ss   = 1'b0;
                spi_mosi = tx_sr[23];
                if (half_done) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                spi_ss   = 1'b0;
                spi_sclk = sclk_hi;
                spi_mosi = tx_sr[23];
                if (half_done && !sclk_hi && last_bit) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            bit_last <= '0;
            gap_cnt  <= '0;
            sclk_hi  <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    gap_cnt <= '0;
                    sclk_hi <= 1'b0;
                    if (cmd_valid) begin
                        bit_last <= last_bit_for(cmd_opcode);
                        tx_sr    <= frame_for(cmd_opcode, cmd_arg);
                    end
                end
                LEAD: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        sclk_hi <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    // Sample in the first cycle sclk is high; the byte is
                    // published together with its 8th sample.
                    if (sclk_hi && div_cnt == '0) begin
                        rx_sr <= {rx_sr[5:0], spi_miso};
                        if (bit_cnt[2:0] == 3'd7) begin
                            rx_byte  <= {rx_sr, spi_miso};
                            rx_valid <= 1'b1;
                        end
                    end
                    if (half_done) begin
                        div_cnt <= '0;
                        if (sclk_hi) begin
                            // MOSI moves on in the same cycle sclk falls.
                            sclk_hi <= 1'b0;
                            tx_sr   <= {tx_sr[22:0], 1'b0};
                        end else if (!last_bit) begin
                            sclk_hi <= 1'b1;
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_spi_command_master.sv
// tb_pipeline_spi_command_master: directed + randomized commands against a frame-level reference model of the SPI master.
// Acts as the SPI slave: captures MOSI on sclk rises, presents MISO bits after sclk falls, times SS, gap and rx strobes.
// Checks reset values, framing per opcode class, MISO capture, back-to-back spacing, mid-frame reset and rst/cmd_valid priority.
module tb_pipeline_spi_command_master;
    localparam int CLK_DIV    = 2;
    localparam int GAP_CYCLES = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [15:0] cmd_arg;
    logic        cmd_ready;
    logic        busy;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        spi_sclk;
    logic        spi_ss;
    logic        spi_mosi;
    logic        spi_miso;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    pipeline_spi_command_master #(
        .CLK_DIV   (CLK_DIV),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_opcode(cmd_opcode),
        .cmd_arg   (cmd_arg),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .spi_sclk  (spi_sclk),
        .spi_ss    (spi_ss),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: bytes on the wire per opcode class.
    function automatic int exp_nbytes(input logic [7:0] op);
        case (op)
            8'h00, 8'hFF:                      return 1;
            8'h01, 8'h02, 8'h03, 8'h06, 8'h0B: return 2;
            default:                           return 3;
        endcase
    endfunction

    // Issues one command and follows its frame as a slave. Starts and ends at a negedge.
    // hold: after accept keep cmd_valid high with (nop, narg) queued; otherwise scramble the
    // idle inputs. abort_rises > 0: assert rst once that many sclk rises have been seen.
    task automatic do_cmd(input logic [7:0] op, input logic [15:0] arg, input logic [23:0] miso_stream,
                          input bit hold, input logic [7:0] nop, input logic [15:0] narg,
                          input int abort_rises, output int acc);
        int n, t, k, rises, ss_low, gap, rx_cnt, rx_bad, mosi_bad, gap_bad, first_rise;
        logic [23:0] mosi_cap, exp_stream, mask;
        logic prev_sclk;
        bit aborted;
        int rise_q[$];

        n = exp_nbytes(op);
        exp_stream = {op, 16'h0000};
        if (n == 2) exp_stream = {op, arg[7:0], 8'h00};
        if (n == 3) exp_stream = {op, arg};
        mask = 24'hFFFFFF << (24 - 8 * n);

        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_arg    = arg;
        spi_miso   = miso_stream[23];
        t = 0;
        while (cmd_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", 32'(t < 2000), 32'd1);
        @(posedge clk);
        #1;
        acc        = cyc;
        cmd_valid  = hold;
        cmd_opcode = hold ? nop : 8'($urandom);
        cmd_arg    = hold ? narg : 16'($urandom);
        @(negedge clk);

        check("lead_ss", 32'(spi_ss), 32'd0);
        check("lead_busy", 32'(busy), 32'd1);
        check("lead_ready", 32'(cmd_ready), 32'd0);
        check("lead_mosi", 32'(spi_mosi), 32'(op[7]));

        k = 1; ss_low = 0; rises = 0; prev_sclk = 1'b0; mosi_bad = 0; rx_cnt = 0; rx_bad = 0;
        first_rise = 0; mosi_cap = '0; aborted = 1'b0;
        while (spi_ss === 1'b0 && k < 2000) begin
            ss_low++;
            if (spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
                if (rises == 0) first_rise = k;
                if (rises < 24) mosi_cap[23 - rises] = spi_mosi;
                rises++;
                rise_q.push_back(k);
            end
            if (spi_sclk === 1'b1 && rises >= 1 && rises <= 24 && spi_mosi !== mosi_cap[24 - rises]) mosi_bad++;
            if (spi_sclk === 1'b0 && prev_sclk === 1'b1 && rises < 24) spi_miso = miso_stream[23 - rises];
            if (rx_valid === 1'b1) begin
                if (rx_cnt >= n || rise_q.size() < 8 * (rx_cnt + 1) ||
                    rise_q[8 * (rx_cnt + 1) - 1] + 1 != k ||
                    rx_byte !== miso_stream[23 - 8 * rx_cnt -: 8]) rx_bad++;
                rx_cnt++;
            end
            if (abort_rises > 0 && rises == abort_rises) begin
                aborted = 1'b1;
                break;
            end
            prev_sclk = spi_sclk;
            @(negedge clk);
            k++;
        end

        if (aborted) begin
            check("abort_rx_before", 32'(rx_cnt), 32'(abort_rises / 8));
            check("abort_rx_bad", 32'(rx_bad), 32'd0);
            rst = 1'b1;
            @(negedge clk);
            check("abort_ss", 32'(spi_ss), 32'd1);
            check("abort_sclk", 32'(spi_sclk), 32'd0);
            check("abort_mosi", 32'(spi_mosi), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_rx_valid", 32'(rx_valid), 32'd0);
            rst = 1'b0;
            @(negedge clk);
            check("abort_ready", 32'(cmd_ready), 32'd1);
            check("abort_no_rx_after", 32'(rx_valid), 32'd0);
        end else begin
            check("ss_low_len", 32'(ss_low), 32'(CLK_DIV * (1 + 16 * n)));
            check("first_rise", 32'(first_rise), 32'(1 + CLK_DIV));
            check("sclk_rises", 32'(rises), 32'(8 * n));
            check("mosi_bytes", 32'(mosi_cap & mask), 32'(exp_stream));
            check("mosi_stable", 32'(mosi_bad), 32'd0);
            check("rx_count", 32'(rx_cnt), 32'(n));
            check("rx_bytes_timing", 32'(rx_bad), 32'd0);
            gap = 0;
            gap_bad = 0;
            while (busy === 1'b1 && gap < 1000) begin
                if (spi_ss !== 1'b1 || spi_sclk !== 1'b0 || spi_mosi !== 1'b0 || cmd_ready !== 1'b0) gap_bad++;
                gap++;
                @(negedge clk);
            end
            check("gap_len", 32'(gap), 32'(GAP_CYCLES));
            check("gap_levels", 32'(gap_bad), 32'd0);
            check("idle_ready", 32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        int a0, a1;
        logic [7:0] op;
        logic [15:0] arg;

        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 8'h00; cmd_arg = 16'h0000; spi_miso = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ss", 32'(spi_ss), 32'd1);
        check("rst_sclk", 32'(spi_sclk), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_rx_byte", 32'(rx_byte), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Reset opcode: single byte, MOSI all zero.
        do_cmd(8'h00, 16'h0000, 24'h000000, 1'b0, 8'h00, 16'h0000, 0, a0);
        // Two-byte command.
        do_cmd(8'h01, 16'h0002, 24'h5A3C00, 1'b0, 8'h00, 16'h0000, 0, a0);
        // Three-byte command with 0xA5 on MISO for every byte.
        do_cmd(8'h04, 16'h0123, 24'hA5A5A5, 1'b0, 8'h00, 16'h0000, 0, a0);
        // Back-to-back: second command held valid throughout the first frame.
        do_cmd(8'h06, 16'h0005, 24'h81FF00, 1'b1, 8'h0B, 16'hBEEF, 0, a0);
        do_cmd(8'h0B, 16'hBEEF, 24'h7E0100, 1'b0, 8'h00, 16'h0000, 0, a1);
        check("b2b_spacing", 32'(a1 - a0), 32'(CLK_DIV * (1 + 16 * 2) + GAP_CYCLES + 1));
        // Reset during the second byte of a 3-byte frame.
        do_cmd(8'h05, 16'h1234, 24'hC3C3C3, 1'b0, 8'h00, 16'h0000, 12, a0);
        check("abort_rx_byte_cleared", 32'(rx_byte), 32'h00);
        // rst and cmd_valid in the same cycle: rst wins.
        rst = 1'b1; cmd_valid = 1'b1; cmd_opcode = 8'h0A; cmd_arg = 16'h4321;
        @(negedge clk);
        check("rst_vs_valid_ss", 32'(spi_ss), 32'd1);
        check("rst_vs_valid_busy", 32'(busy), 32'd0);
        rst = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_vs_valid_ready", 32'(cmd_ready), 32'd1);
        // Recovery frame after the abort.
        do_cmd(8'h03, 16'h0001, 24'h123456, 1'b0, 8'h00, 16'h0000, 0, a0);
        // Unknown opcode falls back to 3 bytes; 0xFF is 1 byte.
        do_cmd(8'h9C, 16'hF00D, 24'h0F1E2D, 1'b0, 8'h00, 16'h0000, 0, a0);
        do_cmd(8'hFF, 16'hAAAA, 24'hE70000, 1'b0, 8'h00, 16'h0000, 0, a0);

        // Randomized commands, some issued back-to-back.
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0:       op = 8'($urandom);
                1:       op = 8'($urandom_range(0, 12));
                2:       op = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
                default: op = 8'($urandom_range(1, 11));
            endcase
            arg = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                do_cmd(op, arg, 24'($urandom), 1'b1, ~op, ~arg, 0, a0);
                do_cmd(~op, ~arg, 24'($urandom), 1'b0, 8'h00, 16'h0000, 0, a1);
                check("rand_b2b_spacing", 32'(a1 - a0),
                      32'(CLK_DIV * (1 + 16 * exp_nbytes(op)) + GAP_CYCLES + 1));
            end else begin
                do_cmd(op, arg, 24'($urandom), 1'b0, 8'h00, 16'h0000, 0, a0);
            end
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
